// File: rtl/mac_pkg.sv
// Shared types and sizing for the mac matrix unit and its operand loader.
package mac_pkg;

  localparam int unsigned MAT_SIZE   = 3;
  localparam int unsigned VAR_WIDTH  = 8;
  localparam int unsigned DATA_WIDTH = MAT_SIZE * MAT_SIZE * VAR_WIDTH;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_RSVD = 2'b11
  } mac_op_e;

  typedef enum logic [1:0] {
    StLoadA,
    StLoadB,
    StIssue,
    StDone
  } loader_state_e;

endpackage

// File: rtl/mac_operand_loader.sv
// Packs a serial element stream into row-major A/B operand buses for mac, then issues a
// fixed-length enable window and reports completion.
module mac_operand_loader
  import mac_pkg::*;
#(
  parameter int unsigned MAC_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  elem_valid_i,
  input  logic [VAR_WIDTH-1:0]  elem_data_i,
  output logic                  elem_ready_o,
  input  logic [1:0]            opcode_i,
  input  logic                  clear_i,
  output logic [DATA_WIDTH-1:0] matrixA_o,
  output logic [DATA_WIDTH-1:0] matrixB_o,
  output logic [1:0]            opcode_o,
  output logic                  enable_o,
  output logic                  clr_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam int unsigned NumElem = MAT_SIZE * MAT_SIZE;
  localparam int unsigned CntW    = (NumElem > 1) ? $clog2(NumElem) : 1;
  localparam int unsigned LatW    = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
  localparam logic [CntW-1:0] LastElem = CntW'(NumElem - 1);
  localparam logic [LatW-1:0] LastLat  = LatW'(MAC_LATENCY - 1);

  loader_state_e         state_q;
  logic [CntW-1:0]       cnt_q;
  logic [LatW-1:0]       lat_q;
  logic [DATA_WIDTH-1:0] mat_a_q, mat_b_q;
  mac_op_e               op_q;
  logic                  enable_q, clr_q, busy_q, done_q, error_q;

  logic                  accept, last_elem;
  logic [DATA_WIDTH-1:0] elem_word, elem_mask;

  assign elem_ready_o = ((state_q == StLoadA) || (state_q == StLoadB)) && !clear_i;
  assign accept       = elem_valid_i && elem_ready_o;
  assign last_elem    = (cnt_q == LastElem);

  // Element k lands at byte lane k counted from the MSB end.
  always_comb begin
    elem_word = '0;
    elem_mask = '0;
    for (int e = 0; e < NumElem; e++) begin
      if (cnt_q == CntW'(e)) begin
        elem_word[DATA_WIDTH - 1 - e * VAR_WIDTH -: VAR_WIDTH] = elem_data_i;
        elem_mask[DATA_WIDTH - 1 - e * VAR_WIDTH -: VAR_WIDTH] = '1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StLoadA;
      cnt_q    <= '0;
      lat_q    <= '0;
      mat_a_q  <= '0;
      mat_b_q  <= '0;
      op_q     <= OP_ADD;
      enable_q <= 1'b0;
      clr_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      clr_q   <= clear_i;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (clear_i) begin
        // Buffers are deliberately left intact; only sequencing restarts.
        state_q  <= StLoadA;
        cnt_q    <= '0;
        lat_q    <= '0;
        enable_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StLoadA: begin
            if (accept) begin
              mat_a_q <= (mat_a_q & ~elem_mask) | elem_word;
              if (cnt_q == '0) op_q <= mac_op_e'(opcode_i);
              if (last_elem) begin
                state_q <= StLoadB;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          StLoadB: begin
            if (accept) begin
              mat_b_q <= (mat_b_q & ~elem_mask) | elem_word;
              if (last_elem) begin
                state_q  <= StIssue;
                cnt_q    <= '0;
                lat_q    <= '0;
                busy_q   <= 1'b1;
                enable_q <= (op_q != OP_RSVD);
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          StIssue: begin
            if ((op_q == OP_RSVD) || (lat_q == LastLat)) begin
              state_q  <= StDone;
              enable_q <= 1'b0;
              done_q   <= 1'b1;
              error_q  <= (op_q == OP_RSVD);
            end else begin
              lat_q <= lat_q + 1'b1;
            end
          end
          StDone: begin
            state_q <= StLoadA;
            busy_q  <= 1'b0;
          end
          default: state_q <= StLoadA;
        endcase
      end
    end
  end

  assign matrixA_o = mat_a_q;
  assign matrixB_o = mat_b_q;
  assign opcode_o  = op_q;
  assign enable_o  = enable_q;
  assign clr_o     = clr_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign error_o   = error_q;

endmodule

// File: tb/tb_mac_operand_loader.sv
// Randomized self-checking bench for mac_operand_loader against a simple stream/pack model.
module tb_mac_operand_loader;

  localparam int NE  = mac_pkg::MAT_SIZE * mac_pkg::MAT_SIZE;
  localparam int DW  = mac_pkg::DATA_WIDTH;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          elem_valid = 1'b0;
  logic [7:0]    elem_data = '0;
  logic [1:0]    opcode = '0;
  logic          clear = 1'b0;
  logic          elem_ready_o;
  logic [DW-1:0] matrixA_o, matrixB_o;
  logic [1:0]    opcode_o;
  logic          enable_o, clr_o, busy_o, done_o, error_o;

  int checks = 0;
  int errors = 0;

  logic [7:0]    ea[NE];
  logic [7:0]    eb[NE];
  logic [DW-1:0] exp_a, exp_b;

  int o_en_cnt, o_en_first, o_done_at;
  bit o_err, o_busy_bad, o_junk, o_unstable, o_err_early;

  mac_operand_loader #(
    .MAC_LATENCY(LAT)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .elem_valid_i(elem_valid),
    .elem_data_i (elem_data),
    .elem_ready_o(elem_ready_o),
    .opcode_i    (opcode),
    .clear_i     (clear),
    .matrixA_o   (matrixA_o),
    .matrixB_o   (matrixB_o),
    .opcode_o    (opcode_o),
    .enable_o    (enable_o),
    .clr_o       (clr_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o)
  );

  always #5 clk = ~clk;

  // Row-major flattening: first element ends up in the most significant byte.
  function automatic logic [DW-1:0] pack(input logic [7:0] m[NE]);
    logic [DW-1:0] r = '0;
    for (int k = 0; k < NE; k++) r = (r << 8) | DW'(m[k]);
    return r;
  endfunction

  task automatic fill_random();
    for (int k = 0; k < NE; k++) begin
      ea[k] = 8'($urandom);
      eb[k] = 8'($urandom);
    end
    exp_a = pack(ea);
    exp_b = pack(eb);
  endtask

  // Offers A then B elements; opcode_i is only meaningful on the first offer.
  task automatic drive_stream(input logic [1:0] op, input bit throttle, input int n,
                              output int acc, output int first_at);
    int guard;
    bit will;
    acc = 0;
    first_at = -1;
    guard = 0;
    while (acc < n && guard < 400) begin
      @(negedge clk);
      elem_valid = throttle ? ((guard % 2) != 0) : 1'b1;
      if (acc < NE) elem_data = ea[acc];
      else elem_data = eb[acc - NE];
      opcode = (acc == 0) ? op : 2'($urandom);
      #1 will = elem_valid && elem_ready_o;
      @(posedge clk);
      guard++;
      if (will) begin
        if (acc == 0) first_at = guard;
        acc++;
      end
    end
    checks++;
    if (acc < n) begin
      errors++;
      $display("FAIL stream_timeout accepted %0d required %0d", acc, n);
    end
  endtask

  // Watches the cycles after the last B accept until done_o (offset 1 = first cycle after).
  task automatic observe(input bit offer_junk);
    o_en_cnt = 0; o_en_first = -1; o_done_at = -1;
    o_err = 0; o_busy_bad = 0; o_junk = 0; o_unstable = 0; o_err_early = 0;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      elem_valid = offer_junk;
      elem_data  = 8'($urandom);
      #1;
      if (elem_valid && elem_ready_o) o_junk = 1;
      if (enable_o) begin
        o_en_cnt++;
        if (o_en_first < 0) o_en_first = t;
      end
      if (!busy_o) o_busy_bad = 1;
      if (matrixA_o !== exp_a || matrixB_o !== exp_b) o_unstable = 1;
      if (done_o) begin
        o_done_at = t;
        o_err = error_o;
        break;
      end else if (error_o) o_err_early = 1;
    end
    checks++;
    if (o_done_at < 0) begin
      errors++;
      $display("FAIL done_timeout no done_o within 30 cycles");
    end
  endtask

  task automatic test_reset();
    int acc, fa;
    logic [1:0] op;
    #1;
    checks++;
    if ({matrixA_o, matrixB_o, opcode_o, enable_o, clr_o, busy_o, done_o, error_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got A=%h B=%h op=%b", matrixA_o, matrixB_o, opcode_o);
    end
    @(negedge clk) rst_n = 1'b1;
    #1 checks++;
    if (elem_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b required 1", elem_ready_o);
    end
    fill_random();
    drive_stream(2'b01, 1'b0, 12, acc, fa);
    @(negedge clk);
    elem_valid = 1'b0;
    rst_n = 1'b0;
    #1 checks++;
    if ({matrixA_o, matrixB_o, opcode_o, enable_o, clr_o, busy_o, done_o, error_o} !== '0) begin
      errors++;
      $display("FAIL midop_reset_outputs got A=%h B=%h op=%b", matrixA_o, matrixB_o, opcode_o);
    end
    checks++;
    if (elem_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL midop_reset_ready got %b required 1", elem_ready_o);
    end
    @(negedge clk) rst_n = 1'b1;
    fill_random();
    op = 2'($urandom_range(0, 2));
    drive_stream(op, 1'b0, 2 * NE, acc, fa);
    observe(1'b0);
    checks++;
    if (matrixA_o !== exp_a || matrixB_o !== exp_b || opcode_o !== op) begin
      errors++;
      $display("FAIL post_reset_txn got A=%h B=%h op=%b required A=%h B=%h op=%b",
               matrixA_o, matrixB_o, opcode_o, exp_a, exp_b, op);
    end
  endtask

  task automatic test_add();
    int acc, fa;
    logic [7:0] vals[NE] = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd4, 8'd3, 8'd1, 8'd0, 8'd1};
    logic [DW-1:0] golden = 72'h010203050403010001;
    ea = vals;
    eb = vals;
    exp_a = golden;
    exp_b = golden;
    drive_stream(2'b00, 1'b0, 2 * NE, acc, fa);
    observe(1'b0);
    checks++;
    if (matrixA_o !== golden || matrixB_o !== golden) begin
      errors++;
      $display("FAIL add_pack got A=%h B=%h required %h", matrixA_o, matrixB_o, golden);
    end
    checks++;
    if (opcode_o !== 2'b00) begin
      errors++;
      $display("FAIL add_opcode got %b required 00", opcode_o);
    end
    checks++;
    if (o_en_cnt !== LAT || o_en_first !== 1) begin
      errors++;
      $display("FAIL add_enable got cycles=%0d first=%0d required %0d/1",
               o_en_cnt, o_en_first, LAT);
    end
    checks++;
    if (o_done_at !== LAT + 1 || o_err !== 1'b0 || o_err_early || o_busy_bad || o_unstable) begin
      errors++;
      $display("FAIL add_done got at=%0d err=%b early=%b busy_bad=%b unstable=%b required at=%0d",
               o_done_at, o_err, o_err_early, o_busy_bad, o_unstable, LAT + 1);
    end
  endtask

  task automatic test_throttled();
    int acc, fa;
    logic [1:0] op;
    fill_random();
    op = 2'($urandom_range(0, 2));
    drive_stream(op, 1'b1, 2 * NE, acc, fa);
    observe(1'b1);
    checks++;
    if (matrixA_o !== exp_a || matrixB_o !== exp_b || opcode_o !== op) begin
      errors++;
      $display("FAIL throttle_pack got A=%h B=%h op=%b required A=%h B=%h op=%b",
               matrixA_o, matrixB_o, opcode_o, exp_a, exp_b, op);
    end
    checks++;
    if (o_junk || o_unstable || o_en_cnt !== LAT) begin
      errors++;
      $display("FAIL throttle_issue got junk=%b unstable=%b en=%0d required 0/0/%0d",
               o_junk, o_unstable, o_en_cnt, LAT);
    end
  endtask

  task automatic test_reserved();
    int acc, fa;
    fill_random();
    drive_stream(2'b11, 1'b0, 2 * NE, acc, fa);
    observe(1'b0);
    checks++;
    if (o_en_cnt !== 0) begin
      errors++;
      $display("FAIL rsvd_enable got %0d cycles required 0", o_en_cnt);
    end
    checks++;
    if (o_done_at !== 2 || o_err !== 1'b1 || o_err_early) begin
      errors++;
      $display("FAIL rsvd_done got at=%0d err=%b early=%b required at=2 err=1",
               o_done_at, o_err, o_err_early);
    end
    checks++;
    if (opcode_o !== 2'b11 || matrixA_o !== exp_a || matrixB_o !== exp_b) begin
      errors++;
      $display("FAIL rsvd_pack got op=%b A=%h B=%h", opcode_o, matrixA_o, matrixB_o);
    end
  endtask

  task automatic test_clear();
    int acc, fa;
    logic [1:0] op2;
    fill_random();
    drive_stream(2'b01, 1'b0, NE + 5, acc, fa);
    @(negedge clk);
    elem_valid = 1'b1;
    elem_data  = eb[5];
    clear      = 1'b1;
    #1 checks++;
    if (elem_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL clear_ready got %b required 0", elem_ready_o);
    end
    @(negedge clk);
    clear = 1'b0;
    elem_valid = 1'b0;
    #1 checks++;
    if (clr_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL clr_pulse got clr=%b busy=%b required 1/0", clr_o, busy_o);
    end
    @(negedge clk);
    #1 checks++;
    if (clr_o !== 1'b0) begin
      errors++;
      $display("FAIL clr_width got %b required 0", clr_o);
    end
    fill_random();
    op2 = 2'b10;
    drive_stream(op2, 1'b0, 2 * NE, acc, fa);
    observe(1'b0);
    checks++;
    if (matrixA_o !== exp_a || matrixB_o !== exp_b || opcode_o !== op2) begin
      errors++;
      $display("FAIL clear_restart got A=%h B=%h op=%b required A=%h B=%h op=%b",
               matrixA_o, matrixB_o, opcode_o, exp_a, exp_b, op2);
    end
  endtask

  task automatic test_back_to_back();
    int acc, fa;
    bit op_ok;
    fill_random();
    drive_stream(2'b00, 1'b0, 2 * NE, acc, fa);
    observe(1'b0);
    checks++;
    if (matrixA_o !== exp_a || opcode_o !== 2'b00) begin
      errors++;
      $display("FAIL b2b_first got A=%h op=%b required A=%h op=00", matrixA_o, opcode_o, exp_a);
    end
    fill_random();
    drive_stream(2'b10, 1'b0, 2 * NE, acc, fa);
    checks++;
    if (fa !== 1) begin
      errors++;
      $display("FAIL b2b_first_accept got offer %0d required 1", fa);
    end
    op_ok = 1'b1;
    o_en_cnt = 0;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      elem_valid = 1'b0;
      #1;
      if (enable_o) begin
        o_en_cnt++;
        if (opcode_o !== 2'b10) op_ok = 1'b0;
      end
      if (done_o) break;
    end
    checks++;
    if (!op_ok || o_en_cnt !== LAT || matrixB_o !== exp_b) begin
      errors++;
      $display("FAIL b2b_second got op_ok=%b en=%0d B=%h required 1/%0d/%h",
               op_ok, o_en_cnt, matrixB_o, LAT, exp_b);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_throttled();
    test_reserved();
    test_clear();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
